// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tone_pkg
// Brief   : Shared FSM encoding, frequency limits and beat divider helper.
// Revision: 1.0
// ============================================================================
package tone_pkg;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_PLAY   = 2'd2
    } tone_state_t;

    localparam int unsigned FREQ_MIN_DEF = 20;
    localparam int unsigned FREQ_MAX_DEF = 20000;
    localparam logic [31:0] REST         = 32'd0;

    function automatic int unsigned beat_half(input int unsigned clk_hz,
                                              input int unsigned beat_hz);
        return clk_hz / (2 * beat_hz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/udiv32_seq.sv
`default_nettype none
// ============================================================================
// Module  : udiv32_seq
// Brief   : 32-bit restoring divider, one quotient bit per clock.
// Revision: 1.0
// ============================================================================
module udiv32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [32:0] w_shift;
    logic [32:0] w_trial;

    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= '0;
                r_quo  <= dividend;
                r_div  <= divisor;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                // Borrow out of the trial subtraction means "restore".
                if (w_trial[32]) begin
                    r_rem <= w_shift[31:0];
                    r_quo <= {r_quo[30:0], 1'b0};
                end else begin
                    r_rem <= w_trial[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/tone_player.sv
`default_nettype none
// ============================================================================
// Module  : tone_player
// Brief   : Frequency word to glitch-free square-wave speaker drive + beat clock.
// Revision: 1.0
// ============================================================================
module tone_player
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned BEAT_HZ  = 8,
    parameter int unsigned FREQ_MIN = FREQ_MIN_DEF,
    parameter int unsigned FREQ_MAX = FREQ_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] freq_in,
    output logic        beat,
    output logic        beat_pulse,
    output logic        audio,
    output logic        note_active,
    output logic        range_err
);

    localparam int unsigned BEAT_HALF = beat_half(CLK_HZ, BEAT_HZ);
    localparam int unsigned BEAT_W    = (BEAT_HALF > 1) ? $clog2(BEAT_HALF) : 1;

    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_beat;
    logic              r_beat_pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_cnt   <= '0;
            r_beat       <= 1'b0;
            r_beat_pulse <= 1'b0;
        end else begin
            r_beat_pulse <= 1'b0;
            if (enable) begin
                if (r_beat_cnt == BEAT_W'(BEAT_HALF - 1)) begin
                    r_beat_cnt   <= '0;
                    r_beat       <= ~r_beat;
                    r_beat_pulse <= ~r_beat;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    tone_state_t state, state_next;
    logic [31:0] r_freq;
    logic [31:0] r_half;
    logic [31:0] r_half_next;
    logic [31:0] r_tone_cnt;
    logic        r_audio;
    logic        r_note;
    logic        r_err;
    logic        r_pending;
    logic        r_stopping;

    logic        w_change;
    logic        w_valid;
    logic        w_bad;
    logic        w_tone_tc;
    logic        w_latch;
    logic        w_div_start;
    logic        w_load_first;
    logic        w_set_stop;
    logic        w_end;
    logic [31:0] w_div_freq;
    logic [31:0] w_quo_half;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;

    assign w_change   = (freq_in != r_freq);
    assign w_valid    = (freq_in >= FREQ_MIN) && (freq_in <= FREQ_MAX);
    assign w_bad      = (freq_in != REST) && !w_valid;
    assign w_tone_tc  = (r_tone_cnt == r_half - 32'd1);
    assign w_div_freq = w_latch ? freq_in : r_freq;
    assign w_quo_half = (div_quo == 32'd0) ? 32'd1 : div_quo;

    udiv32_seq u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_div_start),
        .dividend (32'(CLK_HZ)),
        .divisor  (w_div_freq << 1),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_SILENT;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        w_latch      = 1'b0;
        w_div_start  = 1'b0;
        w_load_first = 1'b0;
        w_set_stop   = 1'b0;
        w_end        = 1'b0;
        if (!enable) begin
            state_next = ST_SILENT;
        end else begin
            case (state)
                ST_SILENT: begin
                    if (w_change) begin
                        w_latch = 1'b1;
                        if (w_valid) begin
                            w_div_start = 1'b1;
                            state_next  = ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (w_change) begin
                        w_latch = 1'b1;
                        if (w_valid) w_div_start = 1'b1;
                        else         state_next  = ST_SILENT;
                    end else if (div_done) begin
                        w_load_first = 1'b1;
                        state_next   = ST_PLAY;
                    end else if (!div_busy) begin
                        w_div_start = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_change) begin
                        w_latch = 1'b1;
                        if (w_valid) w_div_start = 1'b1;
                        else         w_set_stop  = 1'b1;
                    end
                    // A rest only ends the note on a high->low toggle.
                    if (w_tone_tc && r_audio && r_stopping && !w_div_start) begin
                        w_end      = 1'b1;
                        state_next = ST_SILENT;
                    end
                end
                default: state_next = ST_SILENT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_freq      <= REST;
            r_half      <= '0;
            r_half_next <= '0;
            r_tone_cnt  <= '0;
            r_audio     <= 1'b0;
            r_note      <= 1'b0;
            r_err       <= 1'b0;
            r_pending   <= 1'b0;
            r_stopping  <= 1'b0;
        end else if (!enable) begin
            r_freq     <= REST;
            r_tone_cnt <= '0;
            r_audio    <= 1'b0;
            r_note     <= 1'b0;
            r_pending  <= 1'b0;
            r_stopping <= 1'b0;
        end else begin
            if (w_latch)          r_freq <= freq_in;
            if (w_latch && w_bad) r_err  <= 1'b1;
            case (state)
                ST_SILENT: begin
                    r_tone_cnt <= '0;
                    r_audio    <= 1'b0;
                    r_note     <= 1'b0;
                    r_pending  <= 1'b0;
                    r_stopping <= 1'b0;
                end
                ST_DIVIDE: begin
                    if (w_load_first) begin
                        r_half     <= w_quo_half;
                        r_tone_cnt <= '0;
                        r_note     <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_end) begin
                        r_tone_cnt <= '0;
                        r_audio    <= 1'b0;
                        r_note     <= 1'b0;
                        r_pending  <= 1'b0;
                        r_stopping <= 1'b0;
                    end else begin
                        // New half-period only takes effect on a toggle boundary.
                        if (w_tone_tc) begin
                            r_tone_cnt <= '0;
                            r_audio    <= ~r_audio;
                            if (r_pending) begin
                                r_half    <= r_half_next;
                                r_pending <= 1'b0;
                            end
                        end else begin
                            r_tone_cnt <= r_tone_cnt + 32'd1;
                        end
                        if (w_div_start) begin
                            r_pending  <= 1'b0;
                            r_stopping <= 1'b0;
                        end else begin
                            if (w_set_stop) r_stopping <= 1'b1;
                            if (div_done && !r_stopping && !w_set_stop) begin
                                r_half_next <= w_quo_half;
                                r_pending   <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign beat        = r_beat;
    assign beat_pulse  = r_beat_pulse;
    assign audio       = r_audio & enable;
    assign note_active = r_note & enable;
    assign range_err   = r_err;

endmodule
`default_nettype wire

// File: doc/tone_player.md
Name: tone_player

Overview:
- Playback back-end. Converts the per-beat 32-bit frequency word (Hz, 0 = rest) into a square-wave speaker drive.
- Also generates the beat clock that paces the recording/playback sequencer.
- Sits between the recorder/keyboard frequency mux and the audio output pin. It is the consumer of the frequency stream that the recorder produces.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BEAT_HZ, 8, beat clock frequency in Hz (50% duty)
- FREQ_MIN, 20, lowest playable frequency in Hz; lower non-zero values are treated as rest
- FREQ_MAX, 20000, highest playable frequency in Hz; higher values are treated as rest

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = audio and beat run; 0 = audio forced low, beat held
- freq_in  in  32  requested tone in Hz; 0 = rest
- beat  out  1  square wave at BEAT_HZ; drives the sequencer clock
- beat_pulse  out  1  one-cycle strobe on each beat rising edge
- audio  out  1  speaker square wave
- note_active  out  1  a valid tone is currently sounding
- range_err  out  1  sticky; set when a non-zero freq_in is outside [FREQ_MIN, FREQ_MAX]

Behaviour:
- Reset (reset=0, async): beat=0, beat_pulse=0, audio=0, note_active=0, range_err=0, all counters 0, FSM=SILENT, latched freq=0.
- Beat generator: counter 0..BEAT_HALF-1, where BEAT_HALF = CLK_HZ/(2*BEAT_HZ) as an integer constant.
  - At terminal count, beat toggles and the counter clears.
  - beat_pulse=1 for exactly the cycle after beat goes 0->1.
  - enable=0 freezes the counter and beat level.
- Half-period: HALF = floor(CLK_HZ / (2*freq)). Computed by a sequential 32-bit restoring divider, 1 quotient bit per cycle, 33 cycles from start to done. No combinational divide.
- FSM states: SILENT, DIVIDE, PLAY.
  - SILENT: audio=0. When freq_in differs from the latched freq (the latched value resets to 0), latch it.
    - Latched value valid -> DIVIDE, start divider.
    - Latched value 0 or out of range -> stay SILENT. If out of range, set range_err.
  - DIVIDE: audio holds its current level.
    - On divider done: load HALF, clear the tone counter, go to PLAY, set note_active=1.
    - If freq_in changes during DIVIDE: abort, re-latch, restart the divider (or go to SILENT if the new value is 0 or invalid).
  - PLAY: tone counter counts 0..HALF-1. At terminal count, audio toggles and the counter clears.
    - freq_in change to a valid value: re-latch and restart the divider in the background. The new HALF is applied only at the next audio toggle, so there are no runt pulses.
    - freq_in change to 0 or invalid: the next audio toggle that lands low ends the note (go to SILENT, note_active=0). An invalid value also sets range_err.
- enable=0 in any state: audio=0 immediately, note_active=0, FSM goes to SILENT, latched freq cleared. On re-enable a valid freq_in restarts via DIVIDE.
- Latency: valid freq_in from SILENT gives the first audio toggle at 1 (latch) + 33 (divide) + HALF cycles.
- HALF=0 (only when CLK_HZ is too small) is clamped to 1.
- range_err clears only on reset.

Decomposition:
- Shared package tone_pkg: FSM state encoding (SILENT/DIVIDE/PLAY), BEAT_HALF helper function, FREQ_MIN/FREQ_MAX defaults, REST constant (32'd0).
- One sub-module, udiv32_seq: sequential restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: busy, done (one-cycle), quotient.
  - start while busy restarts the divide.
- Beat generator and tone counter stay inline.

Test Plan (bench overrides CLK_HZ=1_000_000, BEAT_HZ=1000; BEAT_HALF=500):
- Reset mid-tone: hold freq_in=1000 until audio toggles, then pulse reset=0 -> audio, beat, note_active all 0 on the same cycle; the tone restarts 34 cycles after release plus 500.
- Beat: enable=1 for 3000 cycles -> beat toggles every 500 cycles; beat_pulse high for 1 cycle every 1000 cycles. enable=0 -> beat frozen.
- Basic tone: freq_in=1000 -> note_active after 34 cycles; audio period 1000 cycles (HALF=500). freq_in=440 -> HALF=1136.
- Glitch-free change: switch freq_in 1000->2000 mid-half-period -> the current half completes at 500 cycles; subsequent halves are 250 cycles; no high or low pulse shorter than 250.
- Rest and invalid: freq_in=0 during PLAY -> audio ends low, note_active=0. freq_in=5 -> stays SILENT, range_err=1 and stays 1 after freq_in=1000.
- Change during DIVIDE: freq_in 1000 then 500 ten cycles later -> divider restarts; HALF=1000; no note_active pulse before the second divide completes.
